// File: rtl/stream_demux_2way_pkg.sv
// Shared select encodings and defaults for the 1-to-2 stream demux.
// The same encodings drive the datapath 2:1 select muxes.
package stream_demux_2way_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  localparam int N_DEFAULT  = 32;
  localparam int CW_DEFAULT = 16;

  // One-hot load enable per output from the select bit
  function automatic logic [1:0] sel_decode(input logic sel);
    logic [1:0] en;
    en = 2'b00;
    if (sel == SEL_OUT0) en[0] = 1'b1;
    if (sel == SEL_OUT1) en[1] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/stream_demux_2way_reg_slice.sv
// Single-entry valid/ready register stage.
// Load wins over unload, which gives back-to-back streaming.
module stream_reg_slice #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux_2way.sv
// Registered 1-to-2 valid/ready demux with per-output
// delivered-beat counters.
module stream_demux_2way
  import stream_demux_2way_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [N-1:0]  out1_data,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1
);

  logic [1:0]    load;
  logic          deliver0, deliver1;
  logic [CW-1:0] count0_q, count0_d;
  logic [CW-1:0] count1_q, count1_d;

  // Ready depends only on the selected output, never on in_valid
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (in_sel == SEL_OUT1) in_ready = !out1_valid || out1_ready;
      else                    in_ready = !out0_valid || out0_ready;
    end
  end

  assign load = (in_valid && in_ready) ? sel_decode(in_sel) : 2'b00;

  stream_reg_slice #(.N(N)) u_slice0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load[0]),
    .in_data   (in_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data)
  );

  stream_reg_slice #(.N(N)) u_slice1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load[1]),
    .in_data   (in_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data)
  );

  assign deliver0 = out0_valid && out0_ready;
  assign deliver1 = out1_valid && out1_ready;

  always_comb begin
    count0_d = count0_q + CW'(deliver0);
    count1_d = count1_q + CW'(deliver1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign count0 = count0_q;
  assign count1 = count1_q;

endmodule

// File: tb/tb_stream_demux_2way.sv
// Scoreboard bench for stream_demux_2way: stimulus pushes accepted
// beats per output, a negedge monitor pops on every delivery.
module tb_stream_demux_2way;

  localparam int N  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          in_sel = 1'b0;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0, out1_ready = 1'b0;
  logic [N-1:0]  out0_data, out1_data;
  logic [CW-1:0] count0, count1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [N-1:0]  q0[$];
  logic [N-1:0]  q1[$];
  logic [N-1:0]  last0 = '0, last1 = '0;
  logic [CW-1:0] cnt0 = '0, cnt1 = '0;
  logic          rnd_on = 1'b0;

  stream_demux_2way #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .count0     (count0),
    .count1     (count1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: each output is a queue of capacity one.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      begin
        logic          exp_rdy;
        logic [N-1:0]  e0, e1;
        logic          d0, d1;
        exp_rdy = 1'b0;
        if (!reset)
          exp_rdy = in_sel ? (q1.size() == 0 || out1_ready)
                           : (q0.size() == 0 || out0_ready);
        e0 = (q0.size() != 0) ? q0[0] : last0;
        e1 = (q1.size() != 0) ? q1[0] : last1;
        chk("in_ready", in_ready, exp_rdy);
        chk("out0_valid", out0_valid, q0.size() != 0);
        chk("out1_valid", out1_valid, q1.size() != 0);
        chk("out0_data", out0_data, e0);
        chk("out1_data", out1_data, e1);
        chk("count0", count0, cnt0);
        chk("count1", count1, cnt1);
        if (reset) begin
          q0.delete();
          q1.delete();
          last0 = '0;
          last1 = '0;
          cnt0 = '0;
          cnt1 = '0;
        end else begin
          d0 = (q0.size() != 0) && out0_ready;
          d1 = (q1.size() != 0) && out1_ready;
          if (d0) begin
            last0 = q0.pop_front();
            cnt0 = cnt0 + 1'b1;
          end
          if (d1) begin
            last1 = q1.pop_front();
            cnt1 = cnt1 + 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input logic s);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = in_ready && !reset;
      @(posedge clk);
      #1;
      if (acc) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: beat %0h sel %0d never accepted", d, s);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    logic [CW-1:0] pre;

    // 1. Reset held with in_valid asserted
    reset = 1'b1;
    in_valid = 1'b1;
    idle(3);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_v0", out0_valid, 1'b0);
    chk("rst_v1", out1_valid, 1'b0);
    chk("rst_d0", out0_data, '0);
    chk("rst_cnt1", count1, '0);
    in_valid = 1'b0;
    reset = 1'b0;
    idle(1);

    // 2. Alternating stream, both outputs ready
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 8; i++)
      send(N'(i * 'h11), 1'((i - 1) % 2));
    chk("stream_cycles", cyc - t0, 8);
    idle(2);
    chk("stream_cnt0", count0, 4);
    chk("stream_cnt1", count1, 4);

    // 3. out1 stall with head-of-line blocking
    out1_ready = 1'b0;
    send('hA, 1'b1);
    fork
      begin
        send('hB, 1'b1);
        send('hC, 1'b0);
      end
      begin
        idle(3);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_hold", out1_data, 'hA);
        out1_ready = 1'b1;
      end
    join
    idle(3);
    chk("stall_d1", out1_data, 'hB);
    chk("stall_d0", out0_data, 'hC);

    // 4. Simultaneous load and unload on out0
    out0_ready = 1'b0;
    send('h5, 1'b0);
    out0_ready = 1'b1;
    pre = cnt0;
    send('h6, 1'b0);
    chk("lu_valid", out0_valid, 1'b1);
    chk("lu_data", out0_data, 'h6);
    chk("lu_cnt", count0, pre + 1'b1);
    idle(2);

    // 5. Counter wrap at 2^CW
    pulse_reset();
    for (int i = 0; i < 15; i++) send(N'(32'h100 + i), 1'b0);
    idle(1);
    chk("wrap_15", count0, 15);
    send('h200, 1'b0);
    idle(1);
    chk("wrap_0", count0, 0);
    send('h201, 1'b0);
    idle(1);
    chk("wrap_1", count0, 1);

    // 6. Mid-stream reset discards held beats
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send('hD0, 1'b0);
    send('hD1, 1'b1);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    pulse_reset();
    chk("mrst_v0", out0_valid, 1'b0);
    chk("mrst_v1", out1_valid, 1'b0);
    chk("mrst_c0", count0, 0);
    chk("mrst_c1", count1, 0);
    send('hE1, 1'b1);
    idle(2);
    chk("mrst_resume", count1, 1);

    // 7. Randomized traffic and back-pressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send($urandom, 1'($urandom_range(0, 1)));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (rnd_on) begin
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
          end
        end
      end
    join
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(4);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
